muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_iter.sv | 35 +++
 rtl/muldiv_ctrl.sv | 128 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states,
// iteration count and the operand magnitude helper.
package muldiv_pkg;

   localparam int ITER = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   // 0x8000_0000 maps to itself, which is its correct unsigned magnitude.
   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step: shift-add for multiply, restoring subtract for divide.
// acc is the upper half (partial product / remainder), lsr the lower half.
module muldiv_iter (
   input  logic        is_div,
   input  logic [31:0] acc,
   input  logic [31:0] lsr,
   input  logic [31:0] opnd,
   output logic [31:0] acc_nxt,
   output logic [31:0] lsr_nxt
);

   logic [32:0] sum;
   logic [32:0] trial;
   logic [31:0] diff;

   always_comb begin
      sum   = {1'b0, acc} + {1'b0, (lsr[0] ? opnd : 32'd0)};
      trial = {acc, lsr[31]};
      // Remainder stays below the divisor, so the low 32 bits are exact.
      diff  = trial[31:0] - opnd;
      if (is_div) begin
         if (trial >= {1'b0, opnd}) begin
            acc_nxt = diff;
            lsr_nxt = {lsr[30:0], 1'b1};
         end else begin
            acc_nxt = trial[31:0];
            lsr_nxt = {lsr[30:0], 1'b0};
         end
      end else begin
         acc_nxt = sum[32:1];
         lsr_nxt = {sum[0], lsr[31:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO.
// Define MULDIV_EARLY_OUT_EN to let divides with |a| < |b| skip the iterations.
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        isbusy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   // Handshake: start is accepted only in a cycle where isbusy=0 and flush=0;
   // isbusy then stays high until HI/LO are written or the op is flushed.
   state_e      state;
   logic [4:0]  cnt;
   logic        is_div_q, sign_a, sign_b, b_zero;
   logic [31:0] acc, lsr, opnd;
   logic [31:0] acc_nxt, lsr_nxt;

   op_e         op_in;
   logic        signed_op, early_out;
   logic [31:0] mag_a, mag_b;
   logic        neg;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   muldiv_iter u_iter (
      .is_div  (is_div_q),
      .acc     (acc),
      .lsr     (lsr),
      .opnd    (opnd),
      .acc_nxt (acc_nxt),
      .lsr_nxt (lsr_nxt)
   );

   always_comb begin
      op_in     = op_e'(op);
      signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
      mag_a     = magnitude(src_a, signed_op);
      mag_b     = magnitude(src_b, signed_op);
`ifdef MULDIV_EARLY_OUT_EN
      early_out = op[1] && (src_b != 32'd0) && (mag_a < mag_b);
`else
      early_out = 1'b0;
`endif
      neg      = sign_a ^ sign_b;
      prod_fix = neg ? (64'd0 - {acc, lsr}) : {acc, lsr};
      quo_fix  = b_zero ? 32'hFFFF_FFFF : (neg ? (32'd0 - lsr) : lsr);
      rem_fix  = sign_a ? (32'd0 - acc) : acc;
   end

   assign isbusy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= 5'd0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         is_div_q <= 1'b0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         b_zero   <= 1'b0;
         acc      <= 32'd0;
         lsr      <= 32'd0;
         opnd     <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!flush) begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
                  if (start) begin
                     is_div_q <= op[1];
                     sign_a   <= signed_op & src_a[31];
                     sign_b   <= signed_op & src_b[31];
                     b_zero   <= (src_b == 32'd0);
                     cnt      <= 5'd0;
                     opnd     <= op[1] ? mag_b : mag_a;
                     if (early_out) begin
                        acc   <= mag_a;
                        lsr   <= 32'd0;
                        state <= S_FIX;
                     end else begin
                        acc   <= 32'd0;
                        lsr   <= op[1] ? mag_a : mag_b;
                        state <= S_CALC;
                     end
                  end
               end
            end
            S_CALC: begin
               if (flush) begin
                  state <= S_IDLE;
               end else begin
                  acc <= acc_nxt;
                  lsr <= lsr_nxt;
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'(ITER - 1)) state <= S_FIX;
               end
            end
            S_FIX: begin
               if (!flush) begin
                  if (is_div_q) begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end else begin
                     hi <= prod_fix[63:32];
                     lo <= prod_fix[31:0];
                  end
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: each launch pushes {hi, lo, busy cycles},
// a negedge monitor pops an entry whenever isbusy falls.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, flush, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] src_a, src_b, wdata;
   logic        isbusy;
   logic [31:0] hi, lo;

   int          n_checks = 0;
   int          n_fail = 0;
   int          busy_cnt = 0;
   logic [95:0] exp_q[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   muldiv_ctrl dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .flush  (flush),
      .mthi   (mthi),
      .mtlo   (mtlo),
      .wdata  (wdata),
      .isbusy (isbusy),
      .hi     (hi),
      .lo     (lo)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference model
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
      longint     sa, sb;
      logic [63:0] q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: return 64'(sa * sb);
         2'b01: return {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = 64'(sa / sb);
            r = 64'(sa % sb);
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic logic [31:0] mag(input logic [1:0] o, input logic [31:0] v);
      return (!o[0] && v[31]) ? (32'd0 - v) : v;
   endfunction

   function automatic int exp_busy(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (o[1] && b != 32'd0 && mag(o, a) < mag(o, b)) return 1;
`endif
      return 33;
   endfunction

   // monitor
   initial begin
      logic [95:0] e;
      forever begin
         @(negedge clk);
         if (isbusy === 1'b1) begin
            busy_cnt++;
         end else if (busy_cnt > 0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_completion: got busy=%0d expected no operation", busy_cnt);
            end else begin
               e = exp_q.pop_front();
               chk("sb_hi", {32'd0, hi}, {32'd0, e[95:64]});
               chk("sb_lo", {32'd0, lo}, {32'd0, e[63:32]});
               chk("sb_busy_cycles", 64'(busy_cnt), {32'd0, e[31:0]});
            end
            busy_cnt = 0;
         end
      end
   end

   // driver tasks
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      r = ref_result(o, a, b);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      exp_q.push_back({r, 32'(exp_busy(o, a, b))});
      m_hi = r[63:32];
      m_lo = r[31:0];
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 60; i++) begin
         if (isbusy === 1'b0) return;
         @(negedge clk);
      end
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got isbusy=%b expected 0 within 60 cycles", name, isbusy);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      issue(o, a, b);
      wait_idle("run_op");
   endtask

   task automatic mt(input logic h, input logic l, input logic [31:0] d);
      @(negedge clk);
      mthi = h; mtlo = l; wdata = d;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      if (h) m_hi = d;
      if (l) m_lo = d;
      chk("mt_hi", {32'd0, hi}, {32'd0, m_hi});
      chk("mt_lo", {32'd0, lo}, {32'd0, m_lo});
   endtask

   task automatic launch_abort(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int at_cnt, input bit use_rst);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < at_cnt; i++) begin
         @(negedge clk);
         if (i == 2) begin
            start = 1'b1; op = 2'b01; src_a = $urandom; src_b = $urandom;
            mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
         end else begin
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
         end
      end
      if (use_rst) begin
         rst = 1'b1; m_hi = 32'd0; m_lo = 32'd0;
      end else begin
         flush = 1'b1;
      end
      exp_q.push_back({m_hi, m_lo, 32'(at_cnt + 1)});
      @(negedge clk);
      rst = 1'b0; flush = 1'b0;
      chk(use_rst ? "abort_rst_isbusy" : "abort_flush_isbusy", {63'd0, isbusy}, 64'd0);
      chk("abort_hi", {32'd0, hi}, {32'd0, m_hi});
      chk("abort_lo", {32'd0, lo}, {32'd0, m_lo});
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(1, 20));
         4: return 32'd0 - 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // stimulus
   initial begin
      logic [31:0] w;
      rst = 1'b1; start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = 2'b00; src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      chk("reset_isbusy", {63'd0, isbusy}, 64'd0);
      rst = 1'b0;

      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
      chk("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(2'b11, 32'd100, 32'd0);
      chk("divu_by_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_min_neg1", {hi, lo}, 64'h0000_0000_8000_0000);
      run_op(2'b11, 32'd3, 32'd10);
      chk("divu_3_10", {hi, lo}, 64'h0000_0003_0000_0000);

      mt(1'b1, 1'b0, 32'h0000_1234);
      launch_abort(2'b11, 32'd1000, 32'd7, 10, 1'b0);
      chk("flush_hi_kept", {32'd0, hi}, 64'h1234);

      // start + flush in the same cycle: nothing launches, mthi suppressed
      @(negedge clk);
      start = 1'b1; flush = 1'b1; mthi = 1'b1; op = 2'b01; wdata = 32'h5555_AAAA;
      @(negedge clk);
      start = 1'b0; flush = 1'b0; mthi = 1'b0;
      chk("start_flush_isbusy", {63'd0, isbusy}, 64'd0);
      chk("start_flush_hi", {32'd0, hi}, {32'd0, m_hi});

      mt(1'b1, 1'b1, 32'hCAFE_F00D);

      // mthi together with start: visible at once, overwritten by the result
      w = 32'h0BAD_0BAD;
      @(negedge clk);
      mthi = 1'b1; wdata = w;
      mthi = 1'b1;
      begin
         logic [63:0] r;
         r = ref_result(2'b01, 32'd6, 32'd7);
         start = 1'b1; op = 2'b01; src_a = 32'd6; src_b = 32'd7;
         exp_q.push_back({r, 32'(exp_busy(2'b01, 32'd6, 32'd7))});
         @(negedge clk);
         start = 1'b0; mthi = 1'b0;
         chk("mthi_with_start", {32'd0, hi}, {32'd0, w});
         m_hi = r[63:32];
         m_lo = r[31:0];
      end
      wait_idle("mthi_start");

      launch_abort(2'b00, 32'h1234_5678, 32'h8765_4321, 20, 1'b1);
      run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) mt($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
         run_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand());
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
